z_byte_collector: RTL and testbench

Serial-to-parallel receiver that sits directly downstream of `Top_Level_Module` and consumes its registered output bit `Z`. It hunts for a fixed sync word in the sampled `Z` stream, then assembles the following `DATA_W` bits MSB-first into a word. Completed words are queued in a 2-entry FIFO and presented on a valid/ready output port.

---
 rtl/z_byte_collector.sv | 209 ++++++++++++++++++++
 tb/tb_z_byte_collector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_byte_collector.sv
// z_byte_collector: hunts for SYNC_PAT in the qualified Z bit stream, then
// gathers DATA_W bits MSB-first and queues the word in a 2-entry FIFO that
// drains through a valid/ready port.
// Optional build macro: Z_BYTE_COLLECTOR_PARITY_EN adds a trailing even-parity
// bit per frame; failing frames are discarded and pulse frame_err.
module z_byte_collector #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Z,
    input  logic              z_en,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              overflow,
    output logic              frame_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [SYNC_W-1:0] sync_reg, sync_next, sync_shift;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] data_reg, data_next, data_shift;

    logic              push_valid;
    logic [DATA_W-1:0] push_word;
`ifdef Z_BYTE_COLLECTOR_PARITY_EN
    logic              par_fail;
    logic              frame_err_reg;
`endif

    // Candidate register contents once the current bit is shifted in
    assign sync_shift = {sync_reg[SYNC_W-2:0], Z};
    assign data_shift = {data_reg[DATA_W-2:0], Z};

    // State register together with the sync/data shifters and bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_HUNT;
            sync_reg  <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sync_reg  <= sync_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
        end
    end

    // Next-state logic; everything holds when z_en is low
    always_comb begin
        state_next = state_reg;
        sync_next  = sync_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        if (z_en) begin
            case (state_reg)
                ST_HUNT: begin
                    if (sync_shift == SYNC_PAT) begin
                        // Sync register is left cleared so the next hunt starts fresh
                        state_next = ST_DATA;
                        sync_next  = '0;
                        cnt_next   = '0;
                    end else begin
                        sync_next = sync_shift;
                    end
                end
                ST_DATA: begin
                    data_next = data_shift;
                    if (cnt_reg == LAST_BIT) begin
                        cnt_next = '0;
`ifdef Z_BYTE_COLLECTOR_PARITY_EN
                        state_next = ST_PAR;
`else
                        state_next = ST_HUNT;
`endif
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_PAR: begin
                    state_next = ST_HUNT;
                end
                default: begin
                    state_next = ST_HUNT;
                    sync_next  = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output logic: busy flag and the word/push request handed to the FIFO
    always_comb begin
        busy       = (state_reg != ST_HUNT);
        push_valid = 1'b0;
        push_word  = data_shift;
`ifdef Z_BYTE_COLLECTOR_PARITY_EN
        par_fail   = 1'b0;
`endif
        if (z_en) begin
            case (state_reg)
                ST_DATA: begin
`ifndef Z_BYTE_COLLECTOR_PARITY_EN
                    push_valid = (cnt_reg == LAST_BIT);
`endif
                end
                ST_PAR: begin
`ifdef Z_BYTE_COLLECTOR_PARITY_EN
                    // Even parity: payload plus parity bit must have an even number of ones
                    push_word = data_reg;
                    if (^{data_reg, Z}) begin
                        par_fail = 1'b1;
                    end else begin
                        push_valid = 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

`ifdef Z_BYTE_COLLECTOR_PARITY_EN
    // One-cycle error pulse following a failed parity sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= par_fail;
        end
    end
    assign frame_err = frame_err_reg;
`else
    assign frame_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Two-entry circular FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_reg [2];
    logic              wr_ptr_reg, rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              overflow_reg;
    logic              fifo_pop, fifo_full, push_acc, push_drop;

    assign fifo_pop  = (count_reg != 2'd0) && out_ready;
    assign fifo_full = (count_reg == 2'd2);
    // A pop on the same edge frees a slot, so a full FIFO can still accept
    assign push_acc  = push_valid && (!fifo_full || fifo_pop);
    assign push_drop = push_valid && fifo_full && !fifo_pop;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            // Storage slot written when the write pointer selects it
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_reg[gi] <= '0;
                end else if (push_acc && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_word;
                end
            end
        end
    endgenerate

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_acc, fifo_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_data  = mem_reg[rd_ptr_reg];
    assign out_valid = (count_reg != 2'd0);
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_z_byte_collector.sv
// Self-checking bench for z_byte_collector: directed scenarios followed by a
// randomized bit stream, all compared against a queue-based frame model.
module tb_z_byte_collector;

    localparam int               DATA_W   = 8;
    localparam int               SYNC_W   = 4;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1011;
`ifdef Z_BYTE_COLLECTOR_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = SYNC_W + DATA_W + PAR_BITS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              Z = 1'b0;
    logic              z_en = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              overflow;
    logic              frame_err;

    z_byte_collector #(
        .DATA_W  (DATA_W),
        .SYNC_W  (SYNC_W),
        .SYNC_PAT(SYNC_PAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Z        (Z),
        .z_en     (z_en),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // Reference model state: recent hunt bits, bits of the frame in progress,
    // queued words and flags
    bit                hunt_q[$];
    bit                frame_q[$];
    bit                m_busy;
    logic [DATA_W-1:0] m_fifo[$];
    bit                m_ovf;
    bit                m_ferr;
    bit                tx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        hunt_q.delete();
        for (int i = 0; i < SYNC_W; i++) hunt_q.push_back(1'b0);
        frame_q.delete();
        m_busy = 1'b0;
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endfunction

    // One rising edge of the model with the inputs that were applied
    task automatic model_edge(input bit z, input bit en, input bit rdy);
        bit                do_pop;
        bit                have_word;
        logic [DATA_W-1:0] word;
        bit                match;
        int                w;
        int                ones;
        do_pop    = (m_fifo.size() > 0) && rdy;
        have_word = 1'b0;
        word      = '0;
        m_ferr    = 1'b0;
        if (en) begin
            if (!m_busy) begin
                hunt_q.push_back(z);
                void'(hunt_q.pop_front());
                match = 1'b1;
                for (int i = 0; i < SYNC_W; i++)
                    if (hunt_q[i] != SYNC_PAT[SYNC_W-1-i]) match = 1'b0;
                if (match) begin
                    m_busy = 1'b1;
                    frame_q.delete();
                end
            end else begin
                frame_q.push_back(z);
                if (frame_q.size() == DATA_W + PAR_BITS) begin
                    w = 0;
                    ones = 0;
                    for (int i = 0; i < DATA_W; i++) w = w * 2 + int'(frame_q[i]);
                    foreach (frame_q[i]) ones += int'(frame_q[i]);
                    if (PAR_BITS == 0 || (ones % 2) == 0) begin
                        have_word = 1'b1;
                        word = DATA_W'(w);
                    end else begin
                        m_ferr = 1'b1;
                    end
                    m_busy = 1'b0;
                    frame_q.delete();
                    hunt_q.delete();
                    for (int i = 0; i < SYNC_W; i++) hunt_q.push_back(1'b0);
                end
            end
        end
        if (do_pop) begin
            $display("xfer word=%02h t=%0t", m_fifo[0], $time);
            void'(m_fifo.pop_front());
        end
        if (have_word) begin
            if (m_fifo.size() < 2) m_fifo.push_back(word);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/busy"}, 32'(busy), 32'(m_busy));
        check({tag, "/valid"}, 32'(out_valid), 32'(m_fifo.size() > 0));
        check({tag, "/ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "/ferr"}, 32'(frame_err), 32'(m_ferr));
        if (m_fifo.size() > 0) check({tag, "/data"}, 32'(out_data), 32'(m_fifo[0]));
    endtask

    task automatic step(input bit z, input bit en, input bit rdy, input string tag);
        Z = z;
        z_en = en;
        out_ready = rdy;
        @(posedge clk);
        model_edge(z, en, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic load_frame(input logic [DATA_W-1:0] word, input bit bad_par);
        tx_q.delete();
        for (int i = SYNC_W - 1; i >= 0; i--) tx_q.push_back(SYNC_PAT[i]);
        for (int i = DATA_W - 1; i >= 0; i--) tx_q.push_back(word[i]);
        if (PAR_BITS != 0) tx_q.push_back((^word) ^ bad_par);
    endtask

    // Sends tx_q[first..last-1]; the final frame bit uses rdy_last
    task automatic send_bits(input int first, input int last, input bit rdy_body, input bit rdy_last, input string tag);
        for (int i = first; i < last; i++)
            step(tx_q[i], 1'b1, (i == tx_q.size() - 1) ? rdy_last : rdy_body, tag);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] word, input bit rdy_body, input bit rdy_last, input string tag);
        load_frame(word, 1'b0);
        send_bits(0, FRAME_LEN, rdy_body, rdy_last, tag);
    endtask

    // Asynchronous reset asserted between clock edges, released on a falling edge
    task automatic apply_reset(input string tag);
        z_en = 1'b0;
        out_ready = 1'b0;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check({tag, "/valid"}, 32'(out_valid), 32'd0);
        check({tag, "/data"}, 32'(out_data), 32'd0);
        check({tag, "/busy"}, 32'(busy), 32'd0);
        check({tag, "/ovf"}, 32'(overflow), 32'd0);
        check({tag, "/ferr"}, 32'(frame_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check("por/valid", 32'(out_valid), 32'd0);
        check("por/data", 32'(out_data), 32'd0);
        check("por/busy", 32'(busy), 32'd0);
        check("por/ovf", 32'(overflow), 32'd0);
        check("por/ferr", 32'(frame_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single frame: word appears right after the final sampled bit
        load_frame(8'hA5, 1'b0);
        send_bits(0, FRAME_LEN - 1, 1'b0, 1'b0, "t1");
        check("t1/pre_valid", 32'(out_valid), 32'd0);
        send_bits(FRAME_LEN - 1, FRAME_LEN, 1'b0, 1'b0, "t1");
        check("t1/valid", 32'(out_valid), 32'd1);
        check("t1/data", 32'(out_data), 32'hA5);
        check("t1/ovf", 32'(overflow), 32'd0);
        step(1'b0, 1'b0, 1'b1, "t1pop");
        check("t1/empty", 32'(out_valid), 32'd0);

        // Same frame with z_en held low for three cycles mid-payload
        load_frame(8'hA5, 1'b0);
        send_bits(0, SYNC_W + 4, 1'b0, 1'b0, "t2");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "t2gap");
        send_bits(SYNC_W + 4, FRAME_LEN - 1, 1'b0, 1'b0, "t2");
        check("t2/pre_valid", 32'(out_valid), 32'd0);
        send_bits(FRAME_LEN - 1, FRAME_LEN, 1'b0, 1'b0, "t2");
        check("t2/valid", 32'(out_valid), 32'd1);
        check("t2/data", 32'(out_data), 32'hA5);

        // Three frames into a stalled FIFO: third word dropped, overflow sticks
        apply_reset("r3");
        send_frame(8'h11, 1'b0, 1'b0, "t3");
        send_frame(8'h22, 1'b0, 1'b0, "t3");
        send_frame(8'h33, 1'b0, 1'b0, "t3");
        check("t3/ovf", 32'(overflow), 32'd1);
        check("t3/head", 32'(out_data), 32'h11);
        step(1'b0, 1'b0, 1'b1, "t3pop");
        check("t3/second", 32'(out_data), 32'h22);
        step(1'b0, 1'b0, 1'b1, "t3pop");
        check("t3/empty", 32'(out_valid), 32'd0);
        check("t3/ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO popped on the edge the third word completes: nothing lost
        apply_reset("r4");
        send_frame(8'h11, 1'b0, 1'b0, "t4");
        send_frame(8'h22, 1'b0, 1'b0, "t4");
        send_frame(8'h33, 1'b0, 1'b1, "t4");
        check("t4/ovf", 32'(overflow), 32'd0);
        check("t4/head", 32'(out_data), 32'h22);
        step(1'b0, 1'b0, 1'b1, "t4pop");
        check("t4/last", 32'(out_data), 32'h33);
        step(1'b0, 1'b0, 1'b1, "t4pop");
        check("t4/empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-frame with a word queued, then a clean frame
        apply_reset("r5");
        send_frame(8'hA5, 1'b0, 1'b0, "t5");
        load_frame(8'h5A, 1'b0);
        send_bits(0, SYNC_W + 5, 1'b0, 1'b0, "t5");
        check("t5/busy_mid", 32'(busy), 32'd1);
        check("t5/valid_mid", 32'(out_valid), 32'd1);
        apply_reset("t5rst");
        send_frame(8'h3C, 1'b0, 1'b0, "t5b");
        check("t5/data", 32'(out_data), 32'h3C);
        check("t5/valid", 32'(out_valid), 32'd1);

`ifdef Z_BYTE_COLLECTOR_PARITY_EN
        // Parity failure discards the word and pulses frame_err once
        apply_reset("r6");
        load_frame(8'hA5, 1'b1);
        send_bits(0, FRAME_LEN, 1'b0, 1'b0, "t6");
        check("t6/ferr", 32'(frame_err), 32'd1);
        check("t6/valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, "t6idle");
        check("t6/ferr_off", 32'(frame_err), 32'd0);
        load_frame(8'hA5, 1'b0);
        send_bits(0, FRAME_LEN, 1'b0, 1'b0, "t6b");
        check("t6/good", 32'(out_data), 32'hA5);
        check("t6/ferr_good", 32'(frame_err), 32'd0);
`endif

        // Random bit stream with random qualifier and back-pressure
        apply_reset("r7");
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), "rnd");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
